// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage plus IF/ID pipeline register.
// Holds the PC and issues word fetches over a req/ack memory port. Fetches
// that are in flight when decode redirects are discarded.
// Optional build macro IFETCH_PERF_EN adds a saturating bubble counter port.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        or_out,
    input  logic        Branchreg,
    input  logic        IF_ID_Flush,
    input  logic [63:0] PC_CB,
    input  logic [63:0] branch_reg_target,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [63:0] PC_out_IF_ID,
    output logic [63:0] PC_branch_link,
    output logic        if_valid
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [63:0] pc;
        logic [63:0] link;
        logic        valid;
    } ifid_t;

    localparam ifid_t BUBBLE = '{instr: NOP_INSTR, pc: 64'h0, link: 64'h0, valid: 1'b0};

    state_t      state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] pend_q, pend_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [63:0] skid_pc_q, skid_pc_d;
    ifid_t       ifid_q, ifid_d;

    logic        redirect;
    logic [63:0] target;
    logic        ack_v;
    logic [63:0] pc_inc;
    logic        take_fetch;
    logic        take_skid;
    logic        load_bubble;

    // Branchreg wins over or_out; stalls mask redirects entirely.
    assign redirect = (or_out | Branchreg) & ~stall;
    assign target   = Branchreg ? branch_reg_target : PC_CB;
    // An ack with no request outstanding is meaningless and ignored.
    assign ack_v    = imem_ack & req_q;
    assign pc_inc   = pc_q + 64'd4;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (ack_v)         state_d = (stall && !redirect) ? S_HOLD : S_FETCH;
                else if (redirect) state_d = S_DROP;
            end
            S_DROP:  if (ack_v)  state_d = S_FETCH;
            S_HOLD:  if (!stall) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: PC, request, pending target, skid buffer, IF/ID
    always_comb begin
        pc_d         = pc_q;
        req_d        = req_q;
        addr_d       = addr_q;
        pend_d       = pend_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        take_fetch   = 1'b0;
        take_skid    = 1'b0;
        case (state_q)
            S_IDLE: begin
                req_d  = 1'b1;
                addr_d = pc_q;
            end
            S_FETCH: begin
                if (ack_v) begin
                    if (redirect) begin
                        pc_d   = target;
                        addr_d = target;
                    end else if (stall) begin
                        // Park the word; fetch resumes at PC+4 once the stall lifts.
                        skid_instr_d = imem_rdata;
                        skid_pc_d    = pc_q;
                        pc_d         = pc_inc;
                        addr_d       = pc_inc;
                        req_d        = 1'b0;
                    end else begin
                        take_fetch = 1'b1;
                        pc_d       = pc_inc;
                        addr_d     = pc_inc;
                    end
                end else if (redirect) begin
                    // Request must stay stable until acked; remember where to go.
                    pend_d = target;
                end
            end
            S_DROP: begin
                if (redirect) pend_d = target;
                if (ack_v) begin
                    pc_d   = redirect ? target : pend_q;
                    addr_d = redirect ? target : pend_q;
                end
            end
            S_HOLD: begin
                if (!stall) begin
                    req_d = 1'b1;
                    if (redirect) begin
                        pc_d   = target;
                        addr_d = target;
                    end else begin
                        take_skid = 1'b1;
                        addr_d    = pc_q;
                    end
                end
            end
            default: ;
        endcase

        // Bubble beats any word load; a stalled IF/ID holds.
        if (stall) begin
            ifid_d = ifid_q;
        end else if (redirect || IF_ID_Flush) begin
            ifid_d = BUBBLE;
        end else if (take_fetch) begin
            ifid_d = '{instr: imem_rdata, pc: pc_q, link: pc_inc, valid: 1'b1};
        end else if (take_skid) begin
            ifid_d = '{instr: skid_instr_q, pc: skid_pc_q, link: skid_pc_q + 64'd4, valid: 1'b1};
        end else begin
            ifid_d = BUBBLE;
        end
        load_bubble = !stall && !ifid_d.valid;
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= RESET_PC;
            req_q        <= 1'b0;
            addr_q       <= RESET_PC;
            pend_q       <= 64'h0;
            skid_instr_q <= 32'h0;
            skid_pc_q    <= 64'h0;
            ifid_q       <= BUBBLE;
        end else begin
            pc_q         <= pc_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            pend_q       <= pend_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_q       <= ifid_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign instruction    = ifid_q.instr;
    assign PC_out_IF_ID   = ifid_q.pc;
    assign PC_branch_link = ifid_q.link;
    assign if_valid       = ifid_q.valid;

`ifdef IFETCH_PERF_EN
    logic [31:0] bubble_q;

    // Saturating count of edges where IF/ID takes a bubble
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                               bubble_q <= 32'h0;
        else if (load_bubble && bubble_q != '1)   bubble_q <= bubble_q + 32'd1;
    end

    assign bubble_count = bubble_q;
`else
    logic unused_bubble;
    assign unused_bubble = load_bubble;
`endif

endmodule
